phy_link_model_16b: RTL and testbench
=====================================

# phy_link_model_16b

Cycle-accurate 16-bit PHY link model for the switch simulation top. It sits directly downstream of an endpoint's PHY transmit interface (phy_tx_data_o/phy_tx_k_o) and feeds one lane of the switch's rd_i bus. It provides:
- running 8b10b disparity feedback to the endpoint;
- a fixed transmission latency;
- a link-state machine (DOWN/TRAIN/UP) that replaces ad-hoc forced-idle muxing;
- single-word error injection, with a counter of injected errors.

## Interface
Parameters:
- g_latency, default 4: transmitter-input to receiver-output delay in clk_ref_i cycles. Legal range 1..16.
- g_train_commas, default 4: number of consecutive comma words required for TRAIN->UP. Legal range 1..15.

Ports:
- clk_ref_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- tx_data_i  in  16  endpoint transmit word.
- tx_k_i  in  2  endpoint K flags; bit 1 qualifies tx_data_i[15:8], bit 0 qualifies tx_data_i[7:0].
- phy_rst_i  in  1  endpoint PHY reset request.
- link_up_i  in  1  test-controlled link/fibre present.
- inject_err_i  in  1  one-cycle pulse requesting a corrupted word.
- tx_disparity_o  out  1  running disparity returned to the endpoint.
- tx_enc_err_o  out  1  transmit encoding error returned to the endpoint.
- rx_data_o  out  16  word delivered to the switch receiver.
- rx_k_o  out  2  K flags delivered to the switch receiver.
- rx_enc_err_o  out  1  receive encoding error delivered with rx_data_o.
- link_state_o  out  2  link state: 00 = DOWN, 01 = TRAIN, 10 = UP.
- err_count_o  out  16  count of accepted injections; saturates at 16'hFFFF.

## Operation
- **State machine**, reset state DOWN:
  - DOWN -> TRAIN when link_up_i=1 and phy_rst_i=0.
  - TRAIN -> UP when g_train_commas consecutive comma words have been sampled. A comma word is tx_k_i[1]=1 and tx_data_i[15:8]=8'hBC.
  - In TRAIN, any non-comma word clears the comma counter.
  - Any state -> DOWN when link_up_i=0 or phy_rst_i=1. This check has priority over every other transition.
- **Delay-line input word**, selected by the current state:
  - DOWN: {data 16'h0000, k 2'b00, err 1}.
  - TRAIN and UP: {tx_data_i, tx_k_i, err 0}.
  - UP with inject_err_i=1: {16'hFFFF, 2'b11, err 1}.
- **Error injection:**
  - An injection is accepted only in UP and only when no DOWN transition occurs in the same cycle.
  - Each accepted injection increments err_count_o by 1, saturating.
  - inject_err_i is ignored in DOWN and TRAIN.
- **Delay line:** the 19-bit word passes through a g_latency-deep shift register. The last stage drives rx_data_o, rx_k_o and rx_enc_err_o.
- **Disparity:**
  - Updated every cycle from tx_data_i/tx_k_i at the delay-line input, not the output, regardless of state.
  - Processing order: upper byte (data[15:8], tx_k_i[1]) first, then lower byte (data[7:0], tx_k_i[0]).
  - Per byte d with flag k:
    - p6 = bit (31 - d[4:0]) of 32'hE8818197.
    - p4 = bit (7 - d[7:5]) of 8'h89.
    - The new disparity is the current disparity inverted if k^p6^p4 = 1, otherwise unchanged.
    - Override: if k=1 and d[1:0] != 0, the disparity is unchanged.
  - phy_rst_i=1 forces tx_disparity_o to 0 on the next edge.
- **Transmit error:** tx_enc_err_o = 1 exactly while the registered state is DOWN.

## Timing
- **Reset values** while rst_i=1 at an edge:
  - State DOWN.
  - Every delay stage = {0, 0, 1}, giving rx_data_o=0, rx_k_o=0, rx_enc_err_o=1.
  - tx_disparity_o=0, tx_enc_err_o=1, link_state_o=00, err_count_o=0.
  - Comma counter 0.
- **Reset mid-operation:** all of the above apply on the next edge, and in-flight delay-line contents are discarded.
- **Datapath latency:**
  - A word sampled on tx_*_i at edge n appears on rx_*_o after edge n+g_latency-1.
  - That is, rx_*_o is valid g_latency edges after sampling and held for exactly one cycle.
- **State latency:**
  - The state register updates one edge after its cause.
  - link_state_o and tx_enc_err_o reflect the registered state with no further delay.
  - The input-word mux uses the registered state. A link drop sampled at edge n therefore first substitutes the DOWN word at edge n+1.
- **Disparity latency:** tx_disparity_o is registered; the value for the word sampled at edge n is visible after edge n.
- **Counter:** err_count_o updates on the same edge the injection is sampled. At 16'hFFFF it holds.
- **Simultaneous events:**
  - inject_err_i together with a link drop: the drop wins, and there is no count and no corruption.
  - phy_rst_i together with link_up_i rising: the state stays DOWN.
- **Comma counter:** saturates at g_train_commas and is cleared on entering DOWN.

## Test plan
- **Reset:** hold rst_i=1 for 3 cycles -> rx_enc_err_o=1, rx_data_o=0, link_state_o=00, tx_enc_err_o=1, err_count_o=0.
- **Bring-up:** link_up_i=1, then send idle word 16'hBC50 with k=2'b10 continuously -> TRAIN one edge later, UP after 4 commas, tx_enc_err_o=0. With g_latency=4, a word 16'h1234 (k=00) sampled at edge n appears on rx_data_o after edge n+3 with rx_enc_err_o=0.
- **Training interrupted:** send 3 commas, then 16'h0001 (k=00), then 4 commas -> UP is reached only after the second run of 4.
- **Injection:** in UP, pulse inject_err_i for 2 separate cycles -> two rx_data_o=16'hFFFF, k=11, err=1 words at the expected latency; err_count_o=2. A pulse in TRAIN leaves the count unchanged.
- **Link drop:** drop link_up_i mid-frame -> state goes DOWN, and after g_latency+1 cycles rx_enc_err_o=1 with data 0. Reasserting link_up_i restarts training.
- **Disparity:** from tx_disparity_o=0 send D21.5 pairs (16'hB5B5, k=00) -> disparity unchanged. A single 16'hBC50 with k=10 -> result matches the byte-ordered rule. phy_rst_i=1 clears tx_disparity_o to 0 on the next edge.

Source files
------------

// File: rtl/phy_link_model_16b.sv
// phy_link_model_16b
// Cycle-accurate model of one 16-bit PHY lane between an endpoint transmitter
// and a switch receiver. It returns running disparity and a transmit error to
// the endpoint, walks a DOWN/TRAIN/UP link-state machine, delays the word by a
// fixed latency, and can replace one word with a corrupted word on request.
module phy_link_model_16b #(
  parameter int g_latency      = 4,
  parameter int g_train_commas = 4
) (
  input  logic        clk_ref_i,
  input  logic        rst_i,
  input  logic [15:0] tx_data_i,
  input  logic [1:0]  tx_k_i,
  input  logic        phy_rst_i,
  input  logic        link_up_i,
  input  logic        inject_err_i,
  output logic        tx_disparity_o,
  output logic        tx_enc_err_o,
  output logic [15:0] rx_data_o,
  output logic [1:0]  rx_k_o,
  output logic        rx_enc_err_o,
  output logic [1:0]  link_state_o,
  output logic [15:0] err_count_o
);

  localparam logic [1:0] ST_DOWN  = 2'b00;
  localparam logic [1:0] ST_TRAIN = 2'b01;
  localparam logic [1:0] ST_UP    = 2'b10;

  localparam int          CW         = $clog2(g_train_commas + 1);
  localparam logic [CW-1:0] COMMA_MAX = CW'(g_train_commas);

  // Delay-line word layout: {data[15:0], k[1:0], err}
  localparam logic [18:0] WORD_DOWN = {16'h0000, 2'b00, 1'b1};
  localparam logic [18:0] WORD_BAD  = {16'hFFFF, 2'b11, 1'b1};

  // Parity lookup tables of the disparity rule, indexed from the MSB
  localparam logic [31:0] P6_TAB = 32'hE8818197;
  localparam logic [7:0]  P4_TAB = 8'h89;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] comma_cnt_reg, comma_cnt_next;
  logic          disparity_reg;
  logic [15:0]   err_count_reg;
  logic [18:0]   word_in;
  logic [18:0]   dly_reg [g_latency];
  logic          link_drop;
  logic          is_comma;
  logic          inject_ok;

  assign link_drop = !link_up_i || phy_rst_i;
  assign is_comma  = tx_k_i[1] && (tx_data_i[15:8] == 8'hBC);
  // A drop in the same cycle wins over an injection request
  assign inject_ok = (state_reg == ST_UP) && inject_err_i && !link_drop;

  // One byte of the disparity rule; K bytes with nonzero low bits never flip
  function automatic logic disp_byte(input logic cur, input logic [7:0] d, input logic k);
    logic p6;
    logic p4;
    p6 = P6_TAB[5'd31 - d[4:0]];
    p4 = P4_TAB[3'd7 - d[7:5]];
    if (k && (d[1:0] != 2'b00))
      disp_byte = cur;
    else
      disp_byte = cur ^ (k ^ p6 ^ p4);
  endfunction

  // State and comma-run registers
  always_ff @(posedge clk_ref_i) begin
    if (rst_i) begin
      state_reg     <= ST_DOWN;
      comma_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      comma_cnt_reg <= comma_cnt_next;
    end
  end

  // Next-state logic: drop has priority, TRAIN counts consecutive commas
  always_comb begin
    state_next     = state_reg;
    comma_cnt_next = comma_cnt_reg;
    if (link_drop) begin
      state_next     = ST_DOWN;
      comma_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_DOWN: begin
          state_next     = ST_TRAIN;
          comma_cnt_next = '0;
        end
        ST_TRAIN: begin
          if (is_comma) begin
            if (comma_cnt_reg < COMMA_MAX)
              comma_cnt_next = comma_cnt_reg + CW'(1);
          end else begin
            comma_cnt_next = '0;
          end
          if (comma_cnt_next == COMMA_MAX)
            state_next = ST_UP;
        end
        ST_UP: state_next = ST_UP;
        default: begin
          state_next     = ST_DOWN;
          comma_cnt_next = '0;
        end
      endcase
    end
  end

  // State-dependent outputs: transmit error and delay-line input word
  always_comb begin
    tx_enc_err_o = (state_reg == ST_DOWN);
    word_in      = {tx_data_i, tx_k_i, 1'b0};
    if (state_reg == ST_DOWN)
      word_in = WORD_DOWN;
    else if (inject_ok)
      word_in = WORD_BAD;
  end

  // Fixed-latency delay line; reset flushes all in-flight words
  generate
    for (genvar gi = 0; gi < g_latency; gi++) begin : g_dly
      always_ff @(posedge clk_ref_i) begin
        if (rst_i)
          dly_reg[gi] <= WORD_DOWN;
        else if (gi == 0)
          dly_reg[gi] <= word_in;
        else
          dly_reg[gi] <= dly_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  // Running disparity from the transmit word, upper byte then lower byte
  always_ff @(posedge clk_ref_i) begin
    if (rst_i || phy_rst_i)
      disparity_reg <= 1'b0;
    else
      disparity_reg <= disp_byte(disp_byte(disparity_reg, tx_data_i[15:8], tx_k_i[1]),
                                 tx_data_i[7:0], tx_k_i[0]);
  end

  // Saturating counter of accepted injections
  always_ff @(posedge clk_ref_i) begin
    if (rst_i)
      err_count_reg <= 16'h0000;
    else if (inject_ok && (err_count_reg != 16'hFFFF))
      err_count_reg <= err_count_reg + 16'h0001;
  end

  assign tx_disparity_o = disparity_reg;
  assign link_state_o   = state_reg;
  assign err_count_o    = err_count_reg;
  assign rx_data_o      = dly_reg[g_latency-1][18:3];
  assign rx_k_o         = dly_reg[g_latency-1][2:1];
  assign rx_enc_err_o   = dly_reg[g_latency-1][0];

endmodule

// File: tb/tb_phy_link_model_16b.sv
// Testbench for phy_link_model_16b: directed bring-up, injection, drop and
// disparity cases with literal expectations, then randomized traffic checked
// every cycle against a behavioural model of the lane.
module tb_phy_link_model_16b;

  localparam int L = 4;
  localparam int N = 4;

  logic        clk_ref_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] tx_data_i = 16'h0000;
  logic [1:0]  tx_k_i = 2'b00;
  logic        phy_rst_i = 1'b0;
  logic        link_up_i = 1'b0;
  logic        inject_err_i = 1'b0;
  logic        tx_disparity_o;
  logic        tx_enc_err_o;
  logic [15:0] rx_data_o;
  logic [1:0]  rx_k_o;
  logic        rx_enc_err_o;
  logic [1:0]  link_state_o;
  logic [15:0] err_count_o;

  int n_cmp = 0;
  int n_bad = 0;

  phy_link_model_16b #(.g_latency(L), .g_train_commas(N)) dut (
    .clk_ref_i     (clk_ref_i),
    .rst_i         (rst_i),
    .tx_data_i     (tx_data_i),
    .tx_k_i        (tx_k_i),
    .phy_rst_i     (phy_rst_i),
    .link_up_i     (link_up_i),
    .inject_err_i  (inject_err_i),
    .tx_disparity_o(tx_disparity_o),
    .tx_enc_err_o  (tx_enc_err_o),
    .rx_data_o     (rx_data_o),
    .rx_k_o        (rx_k_o),
    .rx_enc_err_o  (rx_enc_err_o),
    .link_state_o  (link_state_o),
    .err_count_o   (err_count_o)
  );

  always #5 clk_ref_i = ~clk_ref_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // state: 0 DOWN, 1 TRAIN, 2 UP; words are {data, k, err}
  int          m_state;
  int          m_run;
  int          m_errs;
  bit          m_disp;
  bit          m_valid = 0;
  logic [18:0] m_pipe[$];

  function automatic bit byte_rule(bit cur, int d, bit k);
    int p6;
    int p4;
    p6 = (32'hE8818197 >> (31 - (d % 32))) & 1;
    p4 = (8'h89 >> (7 - (d / 32))) & 1;
    if (k && (d % 4) != 0) return cur;
    return cur ^ ((k + p6 + p4) % 2 == 1);
  endfunction

  initial begin
    forever begin
      @(posedge clk_ref_i);
      if (rst_i) begin
        m_state = 0; m_run = 0; m_errs = 0; m_disp = 0;
        m_pipe.delete();
        for (int i = 0; i < L; i++) m_pipe.push_back({16'h0000, 2'b00, 1'b1});
        m_valid = 1;
      end else if (m_valid) begin
        bit          drop;
        logic [18:0] w;
        drop = !link_up_i || phy_rst_i;
        if (m_state == 0)
          w = {16'h0000, 2'b00, 1'b1};
        else if (m_state == 2 && inject_err_i && !drop) begin
          w = {16'hFFFF, 2'b11, 1'b1};
          if (m_errs < 65535) m_errs++;
        end else
          w = {tx_data_i, tx_k_i, 1'b0};
        m_pipe.push_front(w);
        void'(m_pipe.pop_back());
        if (phy_rst_i) m_disp = 0;
        else m_disp = byte_rule(byte_rule(m_disp, int'(tx_data_i[15:8]), tx_k_i[1]),
                                int'(tx_data_i[7:0]), tx_k_i[0]);
        if (drop) begin
          m_state = 0; m_run = 0;
        end else if (m_state == 0) begin
          m_state = 1; m_run = 0;
        end else if (m_state == 1) begin
          if (tx_k_i[1] && tx_data_i[15:8] == 8'hBC) m_run++;
          else m_run = 0;
          if (m_run >= N) m_state = 2;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  initial begin
    forever begin
      @(negedge clk_ref_i);
      if (m_valid) begin
        chk("rx_data", rx_data_o, m_pipe[L-1][18:3]);
        chk("rx_k", rx_k_o, m_pipe[L-1][2:1]);
        chk("rx_enc_err", rx_enc_err_o, m_pipe[L-1][0]);
        chk("link_state", link_state_o, m_state);
        chk("tx_enc_err", tx_enc_err_o, m_state == 0);
        chk("disparity", tx_disparity_o, m_disp);
        chk("err_count", err_count_o, m_errs);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic lu,
                       input logic prst, input logic inj);
    tx_data_i = d; tx_k_i = k; link_up_i = lu; phy_rst_i = prst; inject_err_i = inj;
    @(posedge clk_ref_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'hBC50, 2'b10, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) drive(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("rst_rx_err", rx_enc_err_o, 1);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_state", link_state_o, 0);
    chk("rst_tx_err", tx_enc_err_o, 1);
    chk("rst_count", err_count_o, 0);
    rst_i = 1'b0;

    // Bring-up
    idle(1);
    chk("bring_train", link_state_o, 1);
    idle(3);
    chk("bring_still_train", link_state_o, 1);
    idle(1);
    chk("bring_up", link_state_o, 2);
    chk("bring_tx_err", tx_enc_err_o, 0);

    // Latency
    drive(16'h1234, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("lat_early", rx_data_o, 16'hBC50);
    idle(1);
    chk("lat_data", rx_data_o, 16'h1234);
    chk("lat_k", rx_k_o, 0);
    chk("lat_err", rx_enc_err_o, 0);

    // Injection in UP, two pulses
    drive(16'hBC50, 2'b10, 1'b1, 1'b0, 1'b1);
    chk("inj_count1", err_count_o, 1);
    idle(2);
    drive(16'hBC50, 2'b10, 1'b1, 1'b0, 1'b1);
    chk("inj_data", rx_data_o, 16'hFFFF);
    chk("inj_k", rx_k_o, 2'b11);
    chk("inj_err", rx_enc_err_o, 1);
    chk("inj_count2", err_count_o, 2);
    idle(2);

    // Injection together with drop: drop wins
    drive(16'hBC50, 2'b10, 1'b0, 1'b0, 1'b1);
    chk("drop_state", link_state_o, 0);
    chk("drop_count", err_count_o, 2);
    idle(L);
    chk("drop_rx_err", rx_enc_err_o, 1);
    chk("drop_rx_data", rx_data_o, 0);
    // Training interrupted; injection ignored in TRAIN
    chk("retrain", link_state_o, 1);
    drive(16'h0001, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("train_inj_count", err_count_o, 2);
    idle(3);
    chk("train_interrupted", link_state_o, 1);
    idle(1);
    chk("train_up2", link_state_o, 2);

    // Disparity
    drive(16'hBC50, 2'b10, 1'b1, 1'b1, 1'b0);
    chk("disp_clear", tx_disparity_o, 0);
    chk("phyrst_down", link_state_o, 0);
    drive(16'hB5B5, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("disp_d21_5", tx_disparity_o, 0);
    drive(16'h0050, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("disp_0050", tx_disparity_o, 1);
    drive(16'hBC50, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("disp_bc50", tx_disparity_o, 1);
    drive(16'hBC51, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("disp_k_override", tx_disparity_o, 0);
    drive(16'hBC50, 2'b10, 1'b1, 1'b1, 1'b0);
    chk("disp_phyrst", tx_disparity_o, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] d;
      logic [1:0]  k;
      d = 16'($urandom);
      k = 2'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        d[15:8] = 8'hBC;
        k[1] = 1'b1;
      end
      rst_i = ($urandom_range(0, 599) == 0);
      drive(d, k, $urandom_range(0, 79) != 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 5) == 0);
    end
    rst_i = 1'b0;
    idle(L + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
